// File: rtl/pipeline_trace_monitor.sv
// pipeline_trace_monitor
//
// Taps the writeback/retire stage of the pipelined CPU. It counts cycles,
// retires, stalls and flushes, buffers retired-instruction records in a
// trace FIFO, and raises end_program once the all-zero halt instruction has
// retired and every buffered record has been drained by the consumer.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   When defined, every record also carries the cycle_count value seen at
//   push time (before that cycle's increment), presented on trace_ts.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   retire_*              retiring instruction (pc, instr, rd, write flag, data)
//   stall, flush          pipeline status for this cycle
//   clr_counters          synchronous clear of all counters and overflow
//   trace_valid/ready     head-of-FIFO handshake
//   trace_pc/instr/rd/reg_write/wdata   head record (trace_ts if enabled)
//   cycle/retire/stall/flush/drop_count saturating performance counters
//   overflow              sticky: a record was dropped
//   end_program           halt retired and FIFO drained
//   state_dbg             FSM state (0 RUN, 1 DRAIN, 2 DONE)
//
// Trace handshake: a record transfers on every clock edge where
// trace_valid && trace_ready; while trace_valid is high and trace_ready is
// low the head record is held unchanged. trace_valid never depends on
// trace_ready.
module pipeline_trace_monitor #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic [31:0]      retire_instr,
    input  logic [4:0]       retire_rd,
    input  logic             retire_reg_write,
    input  logic [XLEN-1:0]  retire_wdata,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_counters,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [XLEN-1:0]  trace_pc,
    output logic [31:0]      trace_instr,
    output logic [4:0]       trace_rd,
    output logic             trace_reg_write,
    output logic [XLEN-1:0]  trace_wdata,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow,
    output logic             end_program,
`ifdef TRACE_TIMESTAMP_EN
    output logic [CNT_W-1:0] trace_ts,
`endif
    output logic [1:0]       state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [31:0]      instr;
        logic [4:0]       rd;
        logic             we;
        logic [XLEN-1:0]  wdata;
`ifdef TRACE_TIMESTAMP_EN
        logic [CNT_W-1:0] ts;
`endif
    } rec_t;

    state_t           state_q, state_d;
    rec_t             mem_q [DEPTH];
    rec_t             mem_d [DEPTH];
    rec_t             rec_in;
    rec_t             head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, retire_q, retire_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d, drop_q, drop_d;
    logic             overflow_q, overflow_d;

    logic run, is_halt, push_req, full, pop, push, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign run      = (state_q == ST_RUN);
    assign is_halt  = retire_valid && (retire_instr == 32'h0);
    assign push_req = run && retire_valid && !is_halt;
    assign full     = (occ_q == FULL_OCC);
    assign pop      = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (is_halt) state_d = ST_DRAIN;
            ST_DRAIN: if (occ_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        end_program = (state_q == ST_DONE);
        state_dbg   = state_q;
    end

    // ---------------- Trace FIFO ----------------
    always_comb begin
        rec_in.pc    = retire_pc;
        rec_in.instr = retire_instr;
        rec_in.rd    = retire_rd;
        rec_in.we    = retire_reg_write;
        rec_in.wdata = retire_wdata;
`ifdef TRACE_TIMESTAMP_EN
        rec_in.ts    = cycle_q;
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = rec_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    assign trace_valid     = (occ_q != '0);
    assign head            = mem_q[rd_ptr_q];
    assign trace_pc        = head.pc;
    assign trace_instr     = head.instr;
    assign trace_rd        = head.rd;
    assign trace_reg_write = head.we;
    assign trace_wdata     = head.wdata;
`ifdef TRACE_TIMESTAMP_EN
    assign trace_ts        = head.ts;
`endif

    // ---------------- Counters ----------------
    // Counting only happens in RUN; the clear is applied last so it wins.
    always_comb begin
        cycle_d    = cycle_q;
        retire_d   = retire_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        if (run) begin
            cycle_d = sat_inc(cycle_q);
            if (retire_valid) retire_d = sat_inc(retire_q);
            if (stall)        stall_d  = sat_inc(stall_q);
            if (flush)        flush_d  = sat_inc(flush_q);
            if (drop) begin
                drop_d     = sat_inc(drop_q);
                overflow_d = 1'b1;
            end
        end
        if (clr_counters) begin
            cycle_d    = '0;
            retire_d   = '0;
            stall_d    = '0;
            flush_d    = '0;
            drop_d     = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            cycle_q    <= '0;
            retire_q   <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            cycle_q    <= cycle_d;
            retire_q   <= retire_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
        end
    end

    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign stall_count  = stall_q;
    assign flush_count  = flush_q;
    assign drop_count   = drop_q;
    assign overflow     = overflow_q;

endmodule

// File: doc/pipeline_trace_monitor.md
Name: pipeline_trace_monitor

Overview:
- Synthesizable successor to the pipelined-CPU bench's cycle counting, register-write display and end_program detection.
- Sits beside cpu_pipelined and taps its writeback/retire stage.
- Counts cycles, retires, stalls and flushes, and buffers retired-instruction records in a FIFO drained over a valid/ready handshake.
- Detects the all-zero halt instruction and asserts end_program only after the trace FIFO has drained.

Parameters:
- XLEN, 64, data/PC width.
- CNT_W, 32, width of each performance counter.
- DEPTH, 8, trace FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- retire_valid  in  1  an instruction retires this cycle.
- retire_pc  in  XLEN  PC of the retiring instruction.
- retire_instr  in  32  instruction word.
- retire_rd  in  5  destination register.
- retire_reg_write  in  1  rd is written.
- retire_wdata  in  XLEN  writeback data.
- stall  in  1  pipeline stalled this cycle.
- flush  in  1  pipeline flushed this cycle.
- clr_counters  in  1  synchronous counter clear.
- trace_valid  out  1  trace_* head entry is valid.
- trace_ready  in  1  consumer accepts the head entry.
- trace_pc  out  XLEN  head entry PC.
- trace_instr  out  32  head entry instruction.
- trace_rd  out  5  head entry rd.
- trace_reg_write  out  1  head entry write flag.
- trace_wdata  out  XLEN  head entry writeback data.
- cycle_count  out  CNT_W  running cycles.
- retire_count  out  CNT_W  retired instructions.
- stall_count  out  CNT_W  stalled cycles.
- flush_count  out  CNT_W  flush events.
- drop_count  out  CNT_W  records lost to overflow.
- overflow  out  1  sticky; a record has been dropped.
- end_program  out  1  halt seen and FIFO drained.

Behaviour:
- Reset: all outputs 0, FIFO empty, state RUN. Reset overrides every other input.
- States:
  - RUN -> DRAIN: retire_valid with retire_instr==32'h0.
  - DRAIN -> DONE: in any cycle where the FIFO is empty.
  - DONE: held until reset.
- end_program = 1 exactly in DONE; it is registered, so it rises the cycle after the FIFO is observed empty in DRAIN.
- Halt instruction:
  - Counted in retire_count.
  - Not pushed to the FIFO.
  - Its cycle counts in cycle_count.
- In DRAIN/DONE:
  - retire_valid, stall and flush are ignored.
  - All counters are frozen; clr_counters is still honoured.
  - FIFO pops continue.
- Counters:
  - cycle_count +1 every cycle in RUN.
  - stall_count +1 per cycle with stall.
  - flush_count +1 per cycle with flush.
  - retire_count +1 per retire_valid.
  - All counters saturate at 2^CNT_W-1 and never wrap.
  - clr_counters zeroes all five counters and overflow. It beats a same-cycle increment: the result is 0.
- FIFO:
  - Push on retire_valid in RUN (non-halt). Pop when trace_valid && trace_ready.
  - A record pushed in cycle N appears on trace_* in cycle N+1 at the earliest.
  - trace_* hold stable while trace_valid && !trace_ready.
  - Head outputs are don't-care when trace_valid=0; the bench must not check them then.
- Boundary conditions:
  - Full with push and no pop: record dropped, drop_count +1, overflow set.
  - Full with simultaneous push and pop: no drop; occupancy unchanged.
  - Empty with push: the push proceeds; a pop in the same cycle is impossible because trace_valid=0.
  - Pointers wrap modulo DEPTH; occupancy is tracked in a counter of log2(DEPTH)+1 bits.
- Reset mid-DRAIN: FIFO contents are discarded and the block returns to RUN.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN, defined:
  - Adds output port trace_ts, width CNT_W.
  - Each record stores the cycle_count value at push, pre-increment; the first RUN cycle after reset has timestamp 0.
  - trace_ts follows the same hold rules as the other trace_* outputs.
- Undefined: port absent; no timestamp storage is inferred.

Test Plan:
- Reset, then 5 addi retires on consecutive cycles (PC 0..16, rd 1..5, wdata 1..5), trace_ready=1 -> 5 records in order with matching pc/rd/wdata; retire_count=5; overflow=0.
- DEPTH=8, trace_ready=0, 10 retires -> FIFO holds the first 8; drop_count=2; overflow=1. Then trace_ready=1 -> exactly those 8 records in order.
- FIFO full, then push with trace_ready=1 in the same cycle -> drop_count unchanged; occupancy stays 8.
- Halt retire (instr 0) with 3 entries queued, trace_ready=0 for 4 cycles then 1 -> end_program stays 0 until the 3rd pop, rises the next cycle; cycle_count frozen; halt not in trace.
- stall high 4 cycles, flush pulsed twice, clr_counters asserted together with a retire -> stall_count=4 and flush_count=2 before the clear; all counters 0 after it.
- Counter saturation (CNT_W=4): run 20 cycles -> cycle_count=15 and holds. With TRACE_TIMESTAMP_EN defined: a retire in the 3rd RUN cycle carries trace_ts=2.
